// File: rtl/csr_pkg.sv
// csr_pkg: shared constants for the machine-mode CSR file.
// Holds CSR addresses, CSR operation encodings, mstatus/mie/mip bit positions,
// interrupt cause codes, misa constants and the RW/RS/RC write-value helper.
package csr_pkg;

  // CSR addresses
  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

  // CSR instruction operation (00 = read only, never writes)
  typedef enum logic [1:0] {
    CSR_OP_READ = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  // mstatus bit positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;

  // mie / mip bit positions
  localparam int IRQ_MSI = 3;
  localparam int IRQ_MTI = 7;
  localparam int IRQ_MEI = 11;

  // Interrupt cause codes
  localparam int CAUSE_MSI = 3;
  localparam int CAUSE_MTI = 7;
  localparam int CAUSE_MEI = 11;

  // misa: MXL field plus the 'I' extension bit
  localparam logic [25:0] MISA_EXT_I = 26'h000_0100;
  localparam logic [1:0]  MISA_MXL32 = 2'd1;
  localparam logic [1:0]  MISA_MXL64 = 2'd2;

  // misa value in the low xlen bits of a 64-bit word
  function automatic logic [63:0] misa_value(input int xlen);
    if (xlen == 64) return {MISA_MXL64, 36'd0, MISA_EXT_I};
    else            return {32'd0, MISA_MXL32, 4'd0, MISA_EXT_I};
  endfunction

  // New CSR value for a given operation applied to the old value
  function automatic logic [63:0] csr_apply(input csr_op_e op,
                                            input logic [63:0] old_val,
                                            input logic [63:0] wdata);
    logic [63:0] res;
    case (op)
      CSR_OP_RW: res = wdata;
      CSR_OP_RS: res = old_val | wdata;
      CSR_OP_RC: res = old_val & ~wdata;
      default:   res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_file_if.sv
// csr_file_if: bundle of the CSR file's execute-stage, trap and interrupt
// signals. The master modport is the core side (drives *_i, reads *_o);
// the slave modport is the CSR file.
//
// Handshake: there is no valid/ready pair. Every *_i strobe (csr_we_i,
// trap_i, mret_i, instret_i) is a single-cycle qualifier sampled at the
// rising clock edge; the *_o read-side outputs are combinational and valid
// in the same cycle as the inputs that select them.
interface csr_file_if #(parameter int XLEN = 32);
  logic            csr_we_i;
  logic [1:0]      csr_op_i;
  logic [11:0]     csr_addr_i;
  logic [XLEN-1:0] csr_wdata_i;
  logic [XLEN-1:0] csr_rdata_o;
  logic            illegal_o;
  logic            trap_i;
  logic [XLEN-1:0] trap_pc_i;
  logic [XLEN-1:0] trap_cause_i;
  logic            mret_i;
  logic            instret_i;
  logic            irq_sw_i;
  logic            irq_timer_i;
  logic            irq_ext_i;
  logic [XLEN-1:0] trap_vec_o;
  logic [XLEN-1:0] mepc_o;
  logic            irq_pending_o;

  modport master (
    output csr_we_i, csr_op_i, csr_addr_i, csr_wdata_i,
    output trap_i, trap_pc_i, trap_cause_i, mret_i, instret_i,
    output irq_sw_i, irq_timer_i, irq_ext_i,
    input  csr_rdata_o, illegal_o, trap_vec_o, mepc_o, irq_pending_o
  );

  modport slave (
    input  csr_we_i, csr_op_i, csr_addr_i, csr_wdata_i,
    input  trap_i, trap_pc_i, trap_cause_i, mret_i, instret_i,
    input  irq_sw_i, irq_timer_i, irq_ext_i,
    output csr_rdata_o, illegal_o, trap_vec_o, mepc_o, irq_pending_o
  );
endinterface

// File: rtl/csr_counter.sv
// csr_counter: 64-bit free-running counter with separately writable halves.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   inc                 increment enable
//   wr_lo / wr_hi       replace low / high 32 bits this cycle
//   wdata_lo / wdata_hi replacement data
//   count               current value
// Any write suppresses the increment for that cycle; wraps all-ones -> 0.
module csr_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata_lo,
  input  logic [31:0] wdata_hi,
  output logic [63:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 64'd0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) count[31:0]  <= wdata_lo;
      if (wr_hi) count[63:32] <= wdata_hi;
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file beside the execute stage.
// Implements mstatus (MIE/MPIE, MPP fixed to 11), misa, mie, mtvec
// (direct/vectored), mscratch, mepc, mcause, mip (registered irq lines) and
// mhartid, with CSRRW/CSRRS/CSRRC semantics and trap/mret arbitration.
// Optional feature macro: CSR_COUNTERS_EN adds 64-bit mcycle/minstret.
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-low reset
//   bus    csr_file_if.slave (CSR access, trap/mret, irq lines, outputs)
// Parameters: XLEN (32 or 64), MTVEC_RESET, HART_ID.
module csr_file
  import csr_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter logic [XLEN-1:0] HART_ID     = '0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  csr_file_if.slave  bus
);

  // Architectural state
  logic            mstatus_mie;
  logic            mstatus_mpie;
  logic [2:0]      mie_q;     // {MEI, MTI, MSI}
  logic [2:0]      mip_q;     // {MEI, MTI, MSI}
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mscratch_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;

  // Read-side views
  logic [XLEN-1:0] mstatus_rd;
  logic [XLEN-1:0] mie_rd;
  logic [XLEN-1:0] mip_rd;
  logic [XLEN-1:0] rdata;
  logic            addr_ok;
  logic            read_only;
  logic            wr_req;
  logic            illegal;
  logic            wr_en;
  logic [XLEN-1:0] wval;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q;
  logic [63:0] minstret_q;
`endif

  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MPP_LO +: 2] = 2'b11;
    mstatus_rd[MSTATUS_MPIE]        = mstatus_mpie;
    mstatus_rd[MSTATUS_MIE]         = mstatus_mie;
  end

  always_comb begin
    mie_rd = '0;
    mie_rd[IRQ_MSI] = mie_q[0];
    mie_rd[IRQ_MTI] = mie_q[1];
    mie_rd[IRQ_MEI] = mie_q[2];
    mip_rd = '0;
    mip_rd[IRQ_MSI] = mip_q[0];
    mip_rd[IRQ_MTI] = mip_q[1];
    mip_rd[IRQ_MEI] = mip_q[2];
  end

  // Address decode and read mux
  always_comb begin
    rdata     = '0;
    addr_ok   = 1'b1;
    read_only = 1'b0;
    case (bus.csr_addr_i)
      ADDR_MSTATUS:  rdata = mstatus_rd;
      ADDR_MISA:     begin rdata = XLEN'(misa_value(XLEN)); read_only = 1'b1; end
      ADDR_MIE:      rdata = mie_rd;
      ADDR_MTVEC:    rdata = mtvec_q;
      ADDR_MSCRATCH: rdata = mscratch_q;
      ADDR_MEPC:     rdata = mepc_q;
      ADDR_MCAUSE:   rdata = mcause_q;
      ADDR_MIP:      begin rdata = mip_rd; read_only = 1'b1; end
      ADDR_MHARTID:  begin rdata = HART_ID; read_only = 1'b1; end
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE:   rdata = XLEN'(mcycle_q);
      ADDR_MINSTRET: rdata = XLEN'(minstret_q);
      // High halves exist only as separate CSRs on a 32-bit hart
      ADDR_MCYCLEH: begin
        if (XLEN == 32) rdata = XLEN'(mcycle_q[63:32]);
        else            addr_ok = 1'b0;
      end
      ADDR_MINSTRETH: begin
        if (XLEN == 32) rdata = XLEN'(minstret_q[63:32]);
        else            addr_ok = 1'b0;
      end
`endif
      default:       addr_ok = 1'b0;
    endcase
  end

  assign wr_req  = bus.csr_we_i && (bus.csr_op_i != CSR_OP_READ);
  assign illegal = !addr_ok || (wr_req && read_only);
  // Trap and mret both outrank a CSR write; the losing write is dropped.
  assign wr_en   = wr_req && !illegal && !bus.trap_i && !bus.mret_i;
  assign wval    = XLEN'(csr_apply(csr_op_e'(bus.csr_op_i), 64'(rdata),
                                   64'(bus.csr_wdata_i)));

  // mstatus, mepc, mcause: trap > mret > CSR write
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mepc_q       <= '0;
      mcause_q     <= '0;
    end else if (bus.trap_i) begin
      mepc_q       <= {bus.trap_pc_i[XLEN-1:2], 2'b00};
      mcause_q     <= bus.trap_cause_i;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (bus.mret_i) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (wr_en) begin
      if (bus.csr_addr_i == ADDR_MSTATUS) begin
        mstatus_mie  <= wval[MSTATUS_MIE];
        mstatus_mpie <= wval[MSTATUS_MPIE];
      end
      if (bus.csr_addr_i == ADDR_MEPC)   mepc_q   <= {wval[XLEN-1:2], 2'b00};
      if (bus.csr_addr_i == ADDR_MCAUSE) mcause_q <= wval;
    end
  end

  // Registers written only by CSR instructions
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mie_q      <= 3'b000;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
    end else if (wr_en) begin
      if (bus.csr_addr_i == ADDR_MIE)
        mie_q <= {wval[IRQ_MEI], wval[IRQ_MTI], wval[IRQ_MSI]};
      // Only modes 00 and 01 are kept; 10/11 collapse to direct mode.
      if (bus.csr_addr_i == ADDR_MTVEC)
        mtvec_q <= {wval[XLEN-1:2], 1'b0, (wval[1:0] == 2'b01)};
      if (bus.csr_addr_i == ADDR_MSCRATCH)
        mscratch_q <= wval;
    end
  end

  // mip samples the level interrupt lines every cycle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) mip_q <= 3'b000;
    else        mip_q <= {bus.irq_ext_i, bus.irq_timer_i, bus.irq_sw_i};
  end

  // Trap target: BASE, or BASE + 4*cause for vectored interrupts
  logic [XLEN-1:0] tvec_base;
  logic [XLEN-1:0] trap_vec;
  assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};

  always_comb begin
    trap_vec = tvec_base;
    if (mtvec_q[0] && bus.trap_cause_i[XLEN-1])
      trap_vec = tvec_base + {bus.trap_cause_i[XLEN-3:0], 2'b00};
  end

  assign bus.csr_rdata_o   = rdata;
  assign bus.illegal_o     = illegal;
  assign bus.trap_vec_o    = trap_vec;
  assign bus.mepc_o        = mepc_q;
  assign bus.irq_pending_o = mstatus_mie && |(mip_q & mie_q);

`ifdef CSR_COUNTERS_EN
  logic [63:0] wval64;
  logic [31:0] hi_wdata;
  logic        cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;

  assign wval64 = 64'(wval);
  // On a 64-bit hart one CSR covers both halves.
  assign hi_wdata  = (XLEN == 64) ? wval64[63:32] : wval64[31:0];
  assign cyc_wr_lo = wr_en && (bus.csr_addr_i == ADDR_MCYCLE);
  assign ins_wr_lo = wr_en && (bus.csr_addr_i == ADDR_MINSTRET);
  assign cyc_wr_hi = (XLEN == 64) ? cyc_wr_lo
                                  : (wr_en && (bus.csr_addr_i == ADDR_MCYCLEH));
  assign ins_wr_hi = (XLEN == 64) ? ins_wr_lo
                                  : (wr_en && (bus.csr_addr_i == ADDR_MINSTRETH));

  csr_counter u_mcycle (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .inc      (1'b1),
    .wr_lo    (cyc_wr_lo),
    .wr_hi    (cyc_wr_hi),
    .wdata_lo (wval64[31:0]),
    .wdata_hi (hi_wdata),
    .count    (mcycle_q)
  );

  csr_counter u_minstret (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .inc      (bus.instret_i),
    .wr_lo    (ins_wr_lo),
    .wr_hi    (ins_wr_hi),
    .wdata_lo (wval64[31:0]),
    .wdata_hi (hi_wdata),
    .count    (minstret_q)
  );
`else
  logic unused_instret;
  assign unused_instret = bus.instret_i;
`endif

endmodule

// File: doc/csr_file.md
# csr_file

Machine-mode CSR file, successor to the single-cycle four-register CSR unit, sitting beside the execute stage of the core. Adds XLEN parametrisation, CSRRW/CSRRS/CSRRC semantics, mscratch, mie/mip with registered interrupt inputs and interrupt-pending generation, vectored mtvec, and optional 64-bit cycle and instret counters. Trap entry, mret and CSR writes are arbitrated in one place.

## Interface
- XLEN, 32, data width; legal values are 32 and 64.
- MTVEC_RESET, 0, reset value of mtvec.
- HART_ID, 0, value returned by mhartid.
- Clocking: one clock, `clk_i`. Reset `rst_i` is asynchronous and active-low.
- clk_i  in  1  clock
- rst_i  in  1  async active-low reset
- csr_we_i  in  1  CSR instruction writes this cycle
- csr_op_i  in  2  01 RW, 10 RS, 11 RC (00 = read only)
- csr_addr_i  in  12  CSR address
- csr_wdata_i  in  XLEN  rs1 value or zero-extended zimm
- csr_rdata_o  out  XLEN  old value of addressed CSR
- illegal_o  out  1  unknown address, or write to read-only CSR
- trap_i  in  1  take exception/interrupt this cycle
- trap_pc_i  in  XLEN  PC saved to mepc
- trap_cause_i  in  XLEN  mcause value; MSB = interrupt
- mret_i  in  1  mret retiring
- instret_i  in  1  instruction retired this cycle
- irq_sw_i, irq_timer_i, irq_ext_i  in  1 each  level interrupt lines
- trap_vec_o  out  XLEN  trap target PC
- mepc_o  out  XLEN  mret target PC
- irq_pending_o  out  1  enabled interrupt pending and globally enabled

## Operation
- Addresses: mstatus 0x300, misa 0x301 (RO, constant RV32I/RV64I), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344 (RO), mhartid 0xF14 (RO).
- mstatus implements MIE[3], MPIE[7], MPP[12:11], with MPP hardwired to 11. Other bits read 0.
- mie and mip implement bits 3 (MSI), 7 (MTI), and 11 (MEI). Other bits read 0.
- mepc[1:0] is forced to 0 on every write path.
- Write value: RW gives wdata; RS gives old|wdata; RC gives old&~wdata. No write occurs unless csr_we_i=1 and csr_op_i≠00.
- illegal_o is combinational. When illegal_o=1, no state changes.
- Trap (trap_i): mepc←trap_pc_i, mcause←trap_cause_i, MPIE←MIE, MIE←0.
- mret (mret_i): MIE←MPIE, MPIE←1.
- Priority: rst_i > trap_i > mret_i > CSR write. A losing write is dropped.
- mip is a one-stage register of {irq_ext_i, irq_timer_i, irq_sw_i}, updated every cycle.
- irq_pending_o = MIE & |(mip & mie).
- trap_vec_o:
  - mtvec mode[1:0]=00 (direct): BASE.
  - mode=01 and cause MSB=1 (vectored interrupt): BASE + 4×cause[XLEN-2:0].
  - Modes 10 and 11 are written as 00.
- Reset values: mstatus=0x1800, mtvec=MTVEC_RESET, mepc=0, mcause=0, mscratch=0, mie=0, mip=0, counters=0.
- Output reset values: csr_rdata_o follows address decode; illegal_o is decode only; irq_pending_o=0.

## Timing
- csr_rdata_o, illegal_o, trap_vec_o and mepc_o are combinational from current state and inputs. Zero latency.
- All updates occur at the next rising edge. A read in the cycle after a write returns the new value.
- Interrupt input to irq_pending_o: 1 cycle.
- Disabling via mie or mstatus clears irq_pending_o in the cycle after the write.
- Reset asserted mid-operation clears all state immediately, with no clock required.

## Configuration
- `CSR_COUNTERS_EN` defined:
  - 64-bit mcycle (0xB00) increments every cycle.
  - 64-bit minstret (0xB02) increments when instret_i=1.
  - For XLEN=32, high halves are at 0xB80 and 0xB82. For XLEN=64, those addresses are illegal.
  - A CSR write to a counter half replaces that half and suppresses the increment in that cycle.
  - Counters wrap from all-ones to 0.
- Undefined: all four addresses are illegal and no counter flops exist.

## Structure
- Package csr_pkg holds:
  - CSR address localparams.
  - csr_op encodings.
  - mstatus/mie bit positions.
  - Interrupt cause codes (3, 7, 11).
  - misa constants.
- Sub-module csr_counter: 64-bit counter with increment enable and low/high write ports, instantiated twice under `CSR_COUNTERS_EN`.

## Test plan
- CSR ops:
  - Stimulus: RW mscratch←0xA5A5_0000; RS 0x0000_00FF; RC 0xA500_0000.
  - Response: reads return old values each step; final mscratch=0x05A5_00FF.
- Trap then mret:
  - Stimulus: MIE=1; trap_i with pc=0x8000_0104, cause=0xB.
  - Response: mepc=0x8000_0104, mcause=0xB, mstatus=0x1880.
  - Stimulus: mret_i.
  - Response: mstatus=0x1888.
- Vectored interrupt:
  - Stimulus: mtvec=0x8000_0001; cause=0x8000_0007.
  - Response: trap_vec_o=0x8000_001C. With cause=0x2, response: 0x8000_0000.
- Interrupt pending:
  - Stimulus: mie=0x80, MIE=1, raise irq_timer_i.
  - Response: irq_pending_o=1 exactly one cycle later.
  - Stimulus: clear MIE.
  - Response: irq_pending_o=0 the next cycle.
- Collision:
  - Stimulus: trap_i and a CSR write to mepc (0x1234) in the same cycle.
  - Response: mepc=trap_pc_i. Also, writing misa asserts illegal_o and changes no state.
- With `CSR_COUNTERS_EN`:
  - Stimulus: write mcycle=0xFFFF_FFFE, mcycleh=0.
  - Response: after 3 cycles, mcycleh=1 and mcycle=1.
  - Stimulus: async reset mid-count.
  - Response: all counters read 0.
